pipe_stall_ctrl: RTL and testbench

Central stall controller for the five-stage MIPS pipeline. Merges stall requests from ID (load-use), EX (multi-cycle divide) and MEM (data SRAM wait) into the per-register `stall` vector consumed by every pipeline register. Sequences the external iterative divider through a start/ready handshake and produces the HI/LO write strobe. Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_stall_ctrl_pkg.sv | 16 +
 rtl/pipe_stall_ctrl_if.sv | 27 ++
 rtl/pipe_stall_ctrl_div_handshake_fsm.sv | 81 ++++++++
 rtl/pipe_stall_ctrl.sv | 56 +++++
 tb/tb_pipe_stall_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared stall-bus definitions for the pipeline stall controller.
// Bit k of a stall vector freezes pipeline register k (0 = PC ... 5 = WB).
package pipe_stall_ctrl_pkg;

  localparam int StallBus = 6;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // Each encoding freezes everything upstream of the requesting stage and bubbles the next one.
  localparam logic [StallBus-1:0] STALL_MEM  = 6'b001111;
  localparam logic [StallBus-1:0] STALL_EX   = 6'b000111;
  localparam logic [StallBus-1:0] STALL_ID   = 6'b000011;
  localparam logic [StallBus-1:0] STALL_NONE = 6'b000000;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Request/response bundle between the pipeline stages, the divider and the stall controller.
interface pipe_stall_ctrl_if #(
  parameter int STALL_W = pipe_stall_ctrl_pkg::StallBus,
  parameter int CNT_W   = 32
);
  logic               stallreq_id;
  logic               ex_div_req;
  logic               ex_div_signed;
  logic               div_ready;
  logic               stallreq_mem;
  logic [STALL_W-1:0] stall;
  logic               div_start;
  logic               div_signed;
  logic               hilo_we;
  logic               div_err;
  logic [CNT_W-1:0]   stall_cnt;

  modport master (
    output stallreq_id, ex_div_req, ex_div_signed, div_ready, stallreq_mem,
    input  stall, div_start, div_signed, hilo_we, div_err, stall_cnt
  );

  modport slave (
    input  stallreq_id, ex_div_req, ex_div_signed, div_ready, stallreq_mem,
    output stall, div_start, div_signed, hilo_we, div_err, stall_cnt
  );
endinterface

// File: rtl/pipe_stall_ctrl_div_handshake_fsm.sv
// Start/ready handshake with the external iterative divider, with a watchdog and HI/LO strobe.
//   state | meaning
//   IDLE  | no divide in flight; a div request launches the divider
//   RUN   | divider busy; watchdog counting
//   DONE  | result (or timeout) in hand; waiting for MEM to release before writing HI/LO
module div_handshake_fsm #(
  parameter int DIV_MAX_CYC = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic ex_div_req,
  input  logic ex_div_signed,
  input  logic div_ready,
  input  logic stallreq_mem,
  output logic div_start,
  output logic div_signed,
  output logic hilo_we,
  output logic div_err,
  output logic div_busy,
  output logic div_idle
);

  localparam int WD_W = $clog2(DIV_MAX_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(DIV_MAX_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic [WD_W-1:0] wd_cnt;
  logic launch;
  logic wd_expire;

  assign launch    = (state == S_IDLE) && ex_div_req;
  // A ready arriving in the final watchdog cycle still counts as a good result.
  assign wd_expire = (state == S_RUN) && !div_ready && (wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (ex_div_req) state_nxt = S_RUN;
      S_RUN:  if (div_ready || wd_expire) state_nxt = S_DONE;
      S_DONE: if (!stallreq_mem) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The HI/LO write coincides with the cycle EX is released, so the result lands as the div retires.
  always_comb begin
    div_idle = (state == S_IDLE);
    div_busy = (state == S_RUN) || ((state == S_DONE) && stallreq_mem);
    hilo_we  = (state == S_DONE) && !stallreq_mem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt     <= '0;
      div_start  <= 1'b0;
      div_signed <= 1'b0;
      div_err    <= 1'b0;
    end else begin
      div_start <= launch;
      if (launch) begin
        wd_cnt     <= '0;
        div_signed <= ex_div_signed;
      end else if (state == S_RUN) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (wd_expire) div_err <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall controller: merges ID/EX/MEM stall requests into the per-register stall vector,
// sequences the divider and keeps a saturating stall-cycle counter.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int STALL_W     = StallBus,
  parameter int DIV_MAX_CYC = 40,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stall_ctrl_if.slave bus
);

  logic               div_busy;
  logic               div_idle;
  logic               ex_stall_req;
  logic [STALL_W-1:0] stall_vec;
  logic [CNT_W-1:0]   stall_cnt;

  div_handshake_fsm #(
    .DIV_MAX_CYC (DIV_MAX_CYC)
  ) u_div_fsm (
    .clk           (clk),
    .rst           (rst),
    .ex_div_req    (bus.ex_div_req),
    .ex_div_signed (bus.ex_div_signed),
    .div_ready     (bus.div_ready),
    .stallreq_mem  (bus.stallreq_mem),
    .div_start     (bus.div_start),
    .div_signed    (bus.div_signed),
    .hilo_we       (bus.hilo_we),
    .div_err       (bus.div_err),
    .div_busy      (div_busy),
    .div_idle      (div_idle)
  );

  // EX holds from the cycle the div shows up, before the FSM has left IDLE.
  assign ex_stall_req = div_busy || (div_idle && bus.ex_div_req);

  always_comb begin
    stall_vec = STALL_W'(STALL_NONE);
    if (bus.stallreq_mem)     stall_vec = STALL_W'(STALL_MEM);
    else if (ex_stall_req)    stall_vec = STALL_W'(STALL_EX);
    else if (bus.stallreq_id) stall_vec = STALL_W'(STALL_ID);
  end

  always_ff @(posedge clk) begin
    if (rst)                            stall_cnt <= '0;
    else if ((|stall_vec) && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign bus.stall     = stall_vec;
  assign bus.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: a cycle-level reference model predicts every output,
// a negedge monitor compares the DUT against the queued predictions.
module tb_pipe_stall_ctrl;

  localparam int DIV_MAX = 40;
  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_DONE = 2;

  typedef struct {
    logic [5:0]  stall;
    logic        start;
    logic        sgn;
    logic        hilo;
    logic        err;
    logic [31:0] cnt;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_stall_ctrl_if #(.STALL_W(6), .CNT_W(32)) bus ();

  pipe_stall_ctrl #(
    .STALL_W     (6),
    .DIV_MAX_CYC (DIV_MAX),
    .CNT_W       (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int      m_phase;
  int      m_age;
  bit      m_start, m_sign, m_err;
  longint  m_cnt;
  int      cyc = 0;

  task automatic model_reset();
    m_phase = PH_IDLE;
    m_age   = 0;
    m_start = 0;
    m_sign  = 0;
    m_err   = 0;
    m_cnt   = 0;
  endtask

  // Stall mask covers every register up to and including the requesting stage's input register.
  function automatic logic [5:0] stall_of(input logic id, input logic req, input logic mem);
    int  stage;
    bit  ex_wait;
    ex_wait = (m_phase == PH_RUN) || (m_phase == PH_DONE && mem) || (m_phase == PH_IDLE && req);
    stage = mem ? 3 : ex_wait ? 2 : id ? 1 : 0;
    if (stage == 0) return 6'd0;
    return 6'((1 << (stage + 1)) - 1);
  endfunction

  task automatic step(input logic id, input logic req, input logic sgn,
                      input logic rdy, input logic mem, input logic r);
    exp_t e;
    @(posedge clk);
    #1;
    rst               = r;
    bus.stallreq_id   = id;
    bus.ex_div_req    = req;
    bus.ex_div_signed = sgn;
    bus.div_ready     = rdy;
    bus.stallreq_mem  = mem;
    e.stall = stall_of(id, req, mem);
    e.start = m_start;
    e.sgn   = m_sign;
    e.hilo  = (m_phase == PH_DONE) && !mem;
    e.err   = m_err;
    e.cnt   = m_cnt[31:0];
    e.cyc   = cyc;
    sb_q.push_back(e);
    if (r) begin
      model_reset();
    end else begin
      if (e.stall != 6'd0 && m_cnt != 64'h0000_0000_FFFF_FFFF) m_cnt++;
      m_start = 0;
      case (m_phase)
        PH_IDLE: if (req) begin
          m_start = 1;
          m_sign  = sgn;
          m_age   = 0;
          m_phase = PH_RUN;
        end
        PH_RUN: begin
          m_age++;
          if (rdy) m_phase = PH_DONE;
          else if (m_age >= DIV_MAX) begin
            m_err   = 1;
            m_phase = PH_DONE;
          end
        end
        default: if (!mem) m_phase = PH_IDLE;
      endcase
    end
    cyc++;
  endtask

  // lat = RUN cycle in which the divider answers (0 = never, let the watchdog fire).
  task automatic div_run(input logic sgn, input int lat, input int mem_hold, input logic keep_req);
    step(0, 1, sgn, 0, 0, 0);
    for (int n = 0; n < DIV_MAX + 5 && m_phase == PH_RUN; n++)
      step(0, 1, sgn, logic'(lat != 0 && m_age + 1 == lat), 0, 0);
    for (int j = 0; j < mem_hold; j++) step(0, 0, 0, 0, 1, 0);
    step(0, keep_req, sgn, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if (bus.stall !== e.stall || bus.div_start !== e.start || bus.div_signed !== e.sgn ||
          bus.hilo_we !== e.hilo || bus.div_err !== e.err || bus.stall_cnt !== e.cnt) begin
        $display("FAIL outputs cyc=%0d: got stall=%b start=%b signed=%b hilo_we=%b err=%b cnt=%0d; want stall=%b start=%b signed=%b hilo_we=%b err=%b cnt=%0d",
                 e.cyc, bus.stall, bus.div_start, bus.div_signed, bus.hilo_we, bus.div_err,
                 bus.stall_cnt, e.stall, e.start, e.sgn, e.hilo, e.err, e.cnt);
      end else begin
        n_pass++;
      end
    end
  end

  initial begin
    rst               = 1'b1;
    bus.stallreq_id   = 1'b0;
    bus.ex_div_req    = 1'b0;
    bus.ex_div_signed = 1'b0;
    bus.div_ready     = 1'b0;
    bus.stallreq_mem  = 1'b0;
    repeat (3) @(posedge clk);
    model_reset();

    repeat (3) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);

    div_run(1, 34, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    div_run(0, 5, 3, 0);
    div_run(1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 1, 0, 0);

    step(0, 1, 1, 0, 0, 0);
    repeat (9) step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0, 0);

    div_run(0, 3, 0, 1);
    div_run(1, 4, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    repeat (6) step(1, 1, 0, 0, 1, 0);

    for (int i = 0; i < 900; i++) begin
      logic id, req, sgn, rdy, mem, r;
      id  = ($urandom_range(0, 3) == 0);
      mem = ($urandom_range(0, 4) == 0);
      req = ($urandom_range(0, 2) != 0);
      sgn = logic'($urandom_range(0, 1));
      rdy = (m_phase == PH_RUN) ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 9) == 0);
      r   = ($urandom_range(0, 299) == 0);
      step(id, req, sgn, rdy, mem, r);
    end

    step(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending predictions, want 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
